// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage hazard controller for the 5-stage MIPS pipeline.
//   Detects load-use hazards, sequences the multi-cycle MULT/DIV unit (MDU), and
//   flushes IF/ID when a branch or jump is taken.
// Latency: all control outputs are combinational from the current inputs and MDU state.
// Backpressure: a stall holds PC and IF/ID and injects a bubble into ID/EX.
//   A stall always takes priority over a flush.
// Optional feature: define HAZARD_STATS_EN to add StallCycles_o, a saturating
//   16-bit count of stall cycles.
// Ports:
//   Clk_i, Rst_i                      clock (rising edge); asynchronous reset, active-high
//   IDEXMemRead_i, IDEXRt_i           load in EX and its destination register
//   IFIDRs_i, IFIDRt_i, IFIDUsesRt_i  source registers of the ID instruction
//   IFIDMfHiLo_i                      ID instruction is MFHI or MFLO
//   MDUStart_i, MDUIsDiv_i            ID instruction starts an MDU op; high for a divide
//   BranchTaken_i                     branch or jump resolved taken in ID
//   PCWrite_o, IFIDWrite_o            load enables for PC and IF/ID
//   IDEXBubble_o, IFIDFlush_o         NOP insertion into ID/EX; clear of IF/ID
//   MDUBusy_o                         MDU operation in flight
//   StallCycles_o                     stall cycle counter (HAZARD_STATS_EN only)
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic       Clk_i,
    input  logic       Rst_i,
    input  logic       IDEXMemRead_i,
    input  logic [4:0] IDEXRt_i,
    input  logic [4:0] IFIDRs_i,
    input  logic [4:0] IFIDRt_i,
    input  logic       IFIDUsesRt_i,
    input  logic       IFIDMfHiLo_i,
    input  logic       MDUStart_i,
    input  logic       MDUIsDiv_i,
    input  logic       BranchTaken_i,
    output logic       PCWrite_o,
    output logic       IFIDWrite_o,
    output logic       IDEXBubble_o,
    output logic       IFIDFlush_o,
`ifdef HAZARD_STATS_EN
    output logic [15:0] StallCycles_o,
`endif
    output logic       MDUBusy_o
);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             mdu_stall;
    logic             stall;

    // A load into $0 never creates a hazard. rt is compared only when the ID
    // instruction actually reads it.
    assign load_use  = IDEXMemRead_i && (IDEXRt_i != 5'd0) &&
                       ((IDEXRt_i == IFIDRs_i) || (IFIDUsesRt_i && (IDEXRt_i == IFIDRt_i)));
    // While the MDU is busy, only HI/LO readers and new MDU ops wait.
    // The last busy cycle (cnt_q == 0) still stalls.
    assign mdu_stall = busy_q && (IFIDMfHiLo_i || MDUStart_i);
    assign stall     = load_use || mdu_stall;

    always_comb begin
        PCWrite_o    = 1'b1;
        IFIDWrite_o  = 1'b1;
        IDEXBubble_o = 1'b0;
        IFIDFlush_o  = BranchTaken_i;
        if (stall) begin
            // A branch whose operands are not ready yet is re-evaluated next cycle.
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            IDEXBubble_o = 1'b1;
            IFIDFlush_o  = 1'b0;
        end
    end

    // The countdown loads N-1 at issue, so Busy stays high for exactly N cycles.
    // A new issue cannot overlap a busy period, because MDUStart stalls while busy.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (MDUStart_i && !stall) begin
            busy_d = 1'b1;
            cnt_d  = MDUIsDiv_i ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        end
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign MDUBusy_o = busy_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // The counter saturates at the maximum value instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench for hazard_stall_ctrl.
// A reference model pushes the expected outputs for each driven cycle.
// The expected entry is popped and compared when the DUT outputs settle.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       uses_rt;
    logic       mfhilo;
    logic       mdu_start;
    logic       mdu_is_div;
    logic       br_taken;
    logic       pc_write;
    logic       ifid_write;
    logic       idex_bubble;
    logic       ifid_flush;
    logic       mdu_busy;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .Clk_i         (clk),
        .Rst_i         (rst),
        .IDEXMemRead_i (mem_read),
        .IDEXRt_i      (ex_rt),
        .IFIDRs_i      (id_rs),
        .IFIDRt_i      (id_rt),
        .IFIDUsesRt_i  (uses_rt),
        .IFIDMfHiLo_i  (mfhilo),
        .MDUStart_i    (mdu_start),
        .MDUIsDiv_i    (mdu_is_div),
        .BranchTaken_i (br_taken),
        .PCWrite_o     (pc_write),
        .IFIDWrite_o   (ifid_write),
        .IDEXBubble_o  (idex_bubble),
        .IFIDFlush_o   (ifid_flush),
`ifdef HAZARD_STATS_EN
        .StallCycles_o (stall_cycles),
`endif
        .MDUBusy_o     (mdu_busy)
    );

    typedef struct {
        logic        pcw;
        logic        ifw;
        logic        bub;
        logic        fl;
        logic        busy;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rem_model = 0;   // busy cycles remaining, including the current one
    int   sc_model  = 0;
    bit   last_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge. Drives one cycle, checks it, then
    // returns at the next falling edge.
    task automatic step(input string tag, input bit mr, input logic [4:0] xrt,
                        input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                        input bit mf, input bit st, input bit dv, input bit br);
        bit   lu, ms, stl;
        exp_t e;
        mem_read   = mr;
        ex_rt      = xrt;
        id_rs      = rs;
        id_rt      = rt;
        uses_rt    = urt;
        mfhilo     = mf;
        mdu_start  = st;
        mdu_is_div = dv;
        br_taken   = br;
        lu  = mr && (xrt != 0) && ((xrt == rs) || (urt && (xrt == rt)));
        ms  = (rem_model > 0) && (mf || st);
        stl = lu || ms;
        e.pcw  = !stl;
        e.ifw  = !stl;
        e.bub  = stl;
        e.fl   = br && !stl;
        e.busy = (rem_model > 0);
        e.sc   = 16'(sc_model);
        exp_q.push_back(e);
        #2;
        e = exp_q.pop_front();
        check({tag, ".pcw"}, 32'(pc_write), 32'(e.pcw));
        check({tag, ".ifw"}, 32'(ifid_write), 32'(e.ifw));
        check({tag, ".bub"}, 32'(idex_bubble), 32'(e.bub));
        check({tag, ".flush"}, 32'(ifid_flush), 32'(e.fl));
        check({tag, ".busy"}, 32'(mdu_busy), 32'(e.busy));
`ifdef HAZARD_STATS_EN
        check({tag, ".stat"}, 32'(stall_cycles), 32'(e.sc));
`endif
        last_stall = !pc_write;
        @(posedge clk);
        if (rem_model > 0) rem_model--;
        else if (st && !stl) rem_model = dv ? 32 : 4;
        if (stl && sc_model < 65535) sc_model++;
        @(negedge clk);
    endtask

    task automatic nop(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        mem_read = 0; ex_rt = 0; id_rs = 0; id_rt = 0; uses_rt = 0;
        mfhilo = 0; mdu_start = 0; mdu_is_div = 0; br_taken = 0;
        #3;
        check("rst.pcw", 32'(pc_write), 32'd1);
        check("rst.ifw", 32'(ifid_write), 32'd1);
        check("rst.bub", 32'(idex_bubble), 32'd0);
        check("rst.flush", 32'(ifid_flush), 32'd0);
        check("rst.busy", 32'(mdu_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Load-use on rs: one stall cycle, then release with the load in MEM.
        step("t1.lu", 1, 5, 5, 7, 1, 0, 0, 0, 0);
        check("t1.stall", 32'(last_stall), 32'd1);
        step("t1.rel", 0, 9, 5, 7, 1, 0, 0, 0, 0);
        check("t1.free", 32'(last_stall), 32'd0);

        // No stall: a load into $0, and a store whose rt is not read as a source.
        step("t2.r0", 1, 0, 0, 0, 1, 0, 0, 0, 0);
        step("t2.sw", 1, 5, 3, 5, 0, 0, 0, 0, 0);
        step("t2.rt", 1, 5, 3, 5, 1, 0, 0, 0, 0);   // rt read as source: stall

        // A taken branch flushes IF/ID; a stall suppresses the flush.
        step("t5.br", 0, 0, 1, 2, 1, 0, 0, 0, 1);
        step("t5.brlu", 1, 6, 6, 2, 1, 0, 0, 0, 1);
        check("t5.nofl", 32'(ifid_flush), 32'd0);

        // MULT, then MFLO: MFLO waits 4 cycles and proceeds on the 5th.
        step("t3.mult", 0, 0, 1, 2, 1, 0, 1, 0, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step("t3.mflo", 0, 0, 0, 0, 0, 1, 0, 0, 0);
            if (!last_stall) break;
            n++;
        end
        check("t3.len", 32'(n), 32'd4);

        // DIV, three independent adds, then DIV: the adds flow past the busy MDU.
        // The second DIV waits out the remaining 29 busy cycles.
        step("t4.div", 0, 0, 1, 2, 1, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step("t4.add", 0, 0, 3, 4, 1, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            step("t4.div2", 0, 0, 1, 2, 1, 0, 1, 1, 0);
            if (!last_stall) break;
            n++;
        end
        check("t4.len", 32'(n), 32'd29);
        for (int i = 0; i < 33; i++) nop("t4.drain");

        // Reset during a DIV aborts it at once; MFHI then proceeds without a stall.
        step("t6.div", 0, 0, 1, 2, 1, 0, 1, 1, 0);
        for (int i = 0; i < 9; i++) nop("t6.run");
        #2 rst = 1'b1;
        #1;
        check("t6.busy", 32'(mdu_busy), 32'd0);
        check("t6.pcw", 32'(pc_write), 32'd1);
        rem_model = 0;
        sc_model  = 0;
        #1 rst = 1'b0;
        @(negedge clk);
        step("t6.mfhi", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("t6.free", 32'(last_stall), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
